// File: rtl/ex_mem_stage.sv
// Pipeline-boundary register (EX/MEM style): advance, bubble, hold and flush with carry feedback.
// Define PIPE_STAGE_PERF_EN to build the saturating stall/bubble performance counters.
module ex_mem_stage #(
   parameter int                   PAYLOAD_W = 110,
   parameter logic [PAYLOAD_W-1:0] KEEP_MASK = {PAYLOAD_W{1'b0}},
   parameter int                   CARRY_W   = 66,
   parameter int                   STALL_W   = 6,
   parameter int                   STAGE     = 3,
   parameter int                   CNT_W     = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [STALL_W-1:0]   stall,
   input  logic                 flush,
   input  logic                 in_valid,
   input  logic [PAYLOAD_W-1:0] in_payload,
   input  logic [CARRY_W-1:0]   carry_i,
   output logic                 out_valid,
   output logic [PAYLOAD_W-1:0] out_payload,
   output logic [CARRY_W-1:0]   carry_o,
   output logic [CNT_W-1:0]     perf_stall_cnt,
   output logic [CNT_W-1:0]     perf_bubble_cnt
);

   typedef enum logic [1:0] {
      ACT_FLUSH,
      ACT_BUBBLE,
      ACT_ADVANCE,
      ACT_HOLD
   } action_e;

   logic                 s_up;
   logic                 s_dn;
   action_e              action;

   logic                 valid_q,   valid_d;
   logic [PAYLOAD_W-1:0] payload_q, payload_d;
   logic [CARRY_W-1:0]   carry_q,   carry_d;

   // Only two stall bits matter here; the rest of the vector belongs to other stages.
   logic                 unused_stall;
   assign unused_stall = ^stall;

   assign s_up = stall[STAGE];
   assign s_dn = stall[STAGE+1];

   // s_dn without s_up cannot occur, so advance ignores s_dn entirely.
   always_comb begin
      if (flush)        action = ACT_FLUSH;
      else if (!s_up)   action = ACT_ADVANCE;
      else if (!s_dn)   action = ACT_BUBBLE;
      else              action = ACT_HOLD;
   end

   always_comb begin
      // NOTE: defaults first so every path assigns every _d signal and no latch is inferred.
      valid_d   = valid_q;
      payload_d = payload_q;
      carry_d   = '0;
      unique case (action)
         ACT_FLUSH: begin
            valid_d   = 1'b0;
            payload_d = '0;
         end
         ACT_BUBBLE: begin
            valid_d   = 1'b0;
            payload_d = payload_q & KEEP_MASK;
            carry_d   = carry_i;
         end
         ACT_ADVANCE: begin
            valid_d   = in_valid;
            payload_d = in_payload;
         end
         ACT_HOLD: begin
            carry_d   = carry_i;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         valid_q   <= 1'b0;
         payload_q <= '0;
         carry_q   <= '0;
      end else begin
         // NOTE: non-blocking assignments so every flop samples pre-edge values.
         valid_q   <= valid_d;
         payload_q <= payload_d;
         carry_q   <= carry_d;
      end
   end

   assign out_valid   = valid_q;
   assign out_payload = payload_q;
   assign carry_o     = carry_q;

`ifdef PIPE_STAGE_PERF_EN
   logic [CNT_W-1:0] stall_cnt_q,  stall_cnt_d;
   logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;

   // Stall cycles count even when flush wins; a flushed bubble does not count.
   always_comb begin
      stall_cnt_d  = stall_cnt_q;
      bubble_cnt_d = bubble_cnt_q;
      if (s_up && (stall_cnt_q != '1))
         stall_cnt_d = stall_cnt_q + CNT_W'(1);
      if ((action == ACT_BUBBLE) && (bubble_cnt_q != '1))
         bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stall_cnt_q  <= '0;
         bubble_cnt_q <= '0;
      end else begin
         stall_cnt_q  <= stall_cnt_d;
         bubble_cnt_q <= bubble_cnt_d;
      end
   end

   assign perf_stall_cnt  = stall_cnt_q;
   assign perf_bubble_cnt = bubble_cnt_q;
`else
   assign perf_stall_cnt  = '0;
   assign perf_bubble_cnt = '0;
`endif

endmodule
